uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Device-side receiver for the host command byte stream: the sender drives rx_data/rx_data_rdy one byte per strobe.
- Parses three line-oriented commands, each terminated by carriage return 0x0d:
  - "L" + 8 hex digits: load a 32-bit key.
  - "E" + ASCII text: encrypt-path plaintext.
  - "D" + hex byte pairs: decrypt-path ciphertext.
- Emits decoded key and data bytes as single-cycle strobes to the cipher datapath, which sits downstream.

Parameters:
- MAXMSG, 256: maximum payload bytes per E/D message; excess bytes are dropped.
- KEY_DIGITS, 8: hex digits required by the L command (key width = 4*KEY_DIGITS).

Ports:
- clk12m  in  1  12 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_data_rdy  in  1  rx_data valid this cycle; one-cycle strobe per byte, may occur on back-to-back cycles.
- key  out  32  last successfully loaded key (4*KEY_DIGITS bits).
- key_vld  out  1  one-cycle pulse when key updates.
- data_out  out  8  payload byte.
- data_vld  out  1  one-cycle pulse, data_out valid.
- data_mode  out  1  0 = encrypt (E), 1 = decrypt (D); valid with data_vld/msg_end.
- msg_end  out  1  one-cycle pulse on the CR closing a good or truncated E/D message.
- msg_len  out  9  bytes emitted in the current/last message; holds at MAXMSG.
- err  out  1  one-cycle pulse on any protocol error.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - Outputs: key=0, all strobes=0, data_out=0, data_mode=0, msg_len=0, busy=0.
  - Internal: state=IDLE, shift register=0, digit count=0, nibble-pending=0.
- Bytes are consumed only on cycles with rx_data_rdy=1. All outputs are registered; every response appears the cycle after the byte is sampled (latency 1). Strobes are 0 on every other cycle.
- Hex digit set: 0x30-0x39, 0x41-0x46, 0x61-0x66 (case-insensitive). Every other byte is non-hex.
- LF (0x0a) is ignored in every state.
- IDLE:
  - "L" -> LOAD: clear shift register and digit count.
  - "E" -> ENC, data_mode=0, msg_len=0.
  - "D" -> DEC, data_mode=1, msg_len=0, nibble-pending=0.
  - CR -> ignored.
  - Any other byte -> err pulse, stay in IDLE.
- LOAD:
  - Hex digit with count < KEY_DIGITS: shift left 4, insert nibble, count+1.
  - CR with count == KEY_DIGITS: key <= shift register, key_vld pulse, go to IDLE.
  - CR with count != KEY_DIGITS: err pulse, key unchanged, go to IDLE.
  - Non-hex byte, or a hex digit with count == KEY_DIGITS: err pulse, go to ERR.
- ENC:
  - Non-CR byte with msg_len < MAXMSG: data_out=byte, data_vld, msg_len+1.
  - Non-CR byte with msg_len == MAXMSG: dropped, err pulse once (first overflow byte only), remain in ENC.
  - CR: msg_end pulse, go to IDLE.
  - Bytes are passed unfiltered; "!" is ordinary payload.
- DEC:
  - Hex digit with nibble-pending=0: hold high nibble, set pending.
  - Hex digit with nibble-pending=1: data_out={held,nibble}, data_vld, msg_len+1 (subject to the same MAXMSG drop and single err), clear pending.
  - CR with pending=0: msg_end, go to IDLE.
  - CR with pending=1: err pulse and msg_end in the same cycle, orphan nibble discarded, go to IDLE.
  - Non-hex, non-CR byte: err pulse, go to ERR (no msg_end).
- ERR: discard all bytes until CR, then go to IDLE with no further pulse.
- Simultaneous events: data_vld and msg_end are never asserted together; err may coincide only with msg_end (odd-nibble case).
- Reset mid-command: abandon the command immediately. key also returns to 0.
- msg_len saturates at MAXMSG and never wraps.

Test Plan:
- "L","0"x8, CR -> key_vld pulse one cycle after the CR byte, key=32'h00000000, err stays 0, busy falls to 0.
- "E","a","b","c","d","!", CR sent back-to-back -> five data_vld pulses with data_out 0x61,0x62,0x63,0x64,0x21 and data_mode=0; msg_end after the CR; msg_len=5.
- "L","1".."8", CR, then "D","f","0","c","0","2","7","6","c","b","0", CR -> key=32'h12345678; data bytes 0xF0,0xC0,0x27,0x6C,0xB0 with data_mode=1; msg_end; msg_len=5.
- Error cases:
  - "L","1","2","3", CR -> err pulse, key keeps its previous value.
  - "Lx12", CR -> err pulse on "x", then silent until CR.
  - "Q" in IDLE -> err pulse.
  - "D","a","b","c", CR -> one byte 0xAB, then err and msg_end in the same cycle.
- "E" + 300 bytes + CR with MAXMSG=256 -> exactly 256 data_vld pulses, a single err on byte 257, msg_len=256, msg_end on CR.
- Assert rst_n=0 after "L","1","2", hold 2 cycles, release, send "E","z", CR -> key=0, no stale key_vld; byte 0x7A emitted with data_mode=0; msg_end.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes the host command byte stream ("L" key load,
// "E" plaintext, "D" hex ciphertext, each closed by CR) into registered
// key/data strobes for the downstream cipher datapath.
module uart_cmd_parser #(
  parameter int unsigned MAXMSG     = 256,
  parameter int unsigned KEY_DIGITS = 8
) (
  input  logic                    clk12m,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_rdy,
  output logic [4*KEY_DIGITS-1:0] key,
  output logic                    key_vld,
  output logic [7:0]              data_out,
  output logic                    data_vld,
  output logic                    data_mode,
  output logic                    msg_end,
  output logic [8:0]              msg_len,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned KW = 4 * KEY_DIGITS;
  localparam int unsigned CW = $clog2(KEY_DIGITS + 1);
  localparam logic [CW-1:0] KEY_CNT = CW'(KEY_DIGITS);
  localparam logic [8:0]    MAX_LEN = 9'(MAXMSG);
  localparam logic [7:0]    CR = 8'h0d;
  localparam logic [7:0]    LF = 8'h0a;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENC,
    S_DEC,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [3:0]    hold_q, hold_d;
  logic          ovf_q, ovf_d;
  logic [KW-1:0] key_q, key_d;
  logic          key_vld_q, key_vld_d;
  logic [7:0]    dout_q, dout_d;
  logic          dvld_q, dvld_d;
  logic          mode_q, mode_d;
  logic          mend_q, mend_d;
  logic [8:0]    len_q, len_d;
  logic          err_q, err_d;

  logic          is_hex;
  logic [3:0]    nib;
  logic          pay_req;
  logic [7:0]    pay_byte;

  // Classify the incoming byte as a hex digit and extract its nibble value.
  always_comb begin
    is_hex = 1'b0;
    nib    = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

  // Next-state and output decode; payload bytes from E and D share one
  // emit path so the MAXMSG drop / single-err rule lives in one place.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    ovf_d     = ovf_q;
    key_d     = key_q;
    key_vld_d = 1'b0;
    dout_d    = dout_q;
    dvld_d    = 1'b0;
    mode_d    = mode_q;
    mend_d    = 1'b0;
    len_d     = len_q;
    err_d     = 1'b0;
    pay_req   = 1'b0;
    pay_byte  = rx_data;

    if (rx_data_rdy && rx_data != LF) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == "L") begin
            state_d = S_LOAD;
            shift_d = '0;
            cnt_d   = '0;
          end else if (rx_data == "E") begin
            state_d = S_ENC;
            mode_d  = 1'b0;
            len_d   = '0;
            ovf_d   = 1'b0;
          end else if (rx_data == "D") begin
            state_d = S_DEC;
            mode_d  = 1'b1;
            len_d   = '0;
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
          end else if (rx_data != CR) begin
            err_d = 1'b1;
          end
        end
        S_LOAD: begin
          if (rx_data == CR) begin
            state_d = S_IDLE;
            if (cnt_q == KEY_CNT) begin
              key_d     = shift_q;
              key_vld_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (is_hex && cnt_q < KEY_CNT) begin
            shift_d = {shift_q[KW-5:0], nib};
            cnt_d   = cnt_q + 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_ENC: begin
          if (rx_data == CR) begin
            mend_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pay_req = 1'b1;
          end
        end
        S_DEC: begin
          if (rx_data == CR) begin
            mend_d  = 1'b1;
            err_d   = pend_q;
            pend_d  = 1'b0;
            state_d = S_IDLE;
          end else if (!is_hex) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (!pend_q) begin
            hold_d = nib;
            pend_d = 1'b1;
          end else begin
            pay_req  = 1'b1;
            pay_byte = {hold_q, nib};
            pend_d   = 1'b0;
          end
        end
        S_ERR: begin
          if (rx_data == CR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (pay_req) begin
      if (len_q < MAX_LEN) begin
        dout_d = pay_byte;
        dvld_d = 1'b1;
        len_d  = len_q + 1'b1;
      end else if (!ovf_q) begin
        err_d = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      hold_q    <= '0;
      ovf_q     <= 1'b0;
      key_q     <= '0;
      key_vld_q <= 1'b0;
      dout_q    <= '0;
      dvld_q    <= 1'b0;
      mode_q    <= 1'b0;
      mend_q    <= 1'b0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      ovf_q     <= ovf_d;
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      dout_q    <= dout_d;
      dvld_q    <= dvld_d;
      mode_q    <= mode_d;
      mend_q    <= mend_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  assign key       = key_q;
  assign key_vld   = key_vld_q;
  assign data_out  = dout_q;
  assign data_vld  = dvld_q;
  assign data_mode = mode_q;
  assign msg_end   = mend_q;
  assign msg_len   = len_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a byte-level command interpreter model is
// compared against the DUT every cycle, plus literal per-scenario checks.
module tb_uart_cmd_parser;

  logic        clk12m;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_rdy;
  logic [31:0] key;
  logic        key_vld;
  logic [7:0]  data_out;
  logic        data_vld;
  logic        data_mode;
  logic        msg_end;
  logic [8:0]  msg_len;
  logic        err;
  logic        busy;

  uart_cmd_parser #(.MAXMSG(256), .KEY_DIGITS(8)) dut (
    .clk12m     (clk12m),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_data_rdy(rx_data_rdy),
    .key        (key),
    .key_vld    (key_vld),
    .data_out   (data_out),
    .data_vld   (data_vld),
    .data_mode  (data_mode),
    .msg_end    (msg_end),
    .msg_len    (msg_len),
    .err        (err),
    .busy       (busy)
  );

  initial clk12m = 1'b0;
  always #42 clk12m = ~clk12m;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: interprets each byte by command-line meaning ("mode" letter,
  // collected digit count, pending nibble), yielding expected outputs.
  typedef struct {
    byte unsigned mode;   // "I" idle, "L" key, "E" enc, "D" dec, "X" skip to CR
    int unsigned  nd;
    logic [31:0]  acc;
    int           pend;   // -1 when no nibble is held
    int unsigned  len;
    bit           ovf;
    logic [31:0]  key;
    bit           kv, dv, me, er, dmode;
    logic [7:0]   dout;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = "I"; r.nd = 0; r.acc = 0; r.pend = -1; r.len = 0; r.ovf = 0;
    r.key = 0; r.kv = 0; r.dv = 0; r.me = 0; r.er = 0; r.dmode = 0; r.dout = 0;
    return r;
  endfunction

  function automatic int hexval(logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic mdl_t emit(mdl_t m, logic [7:0] v);
    mdl_t n = m;
    if (n.len < 256) begin
      n.dout = v; n.dv = 1; n.len++;
    end else if (!n.ovf) begin
      n.er = 1; n.ovf = 1;
    end
    return n;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [7:0] b, logic rdy);
    mdl_t n = m;
    int   h = hexval(b);
    n.kv = 0; n.dv = 0; n.me = 0; n.er = 0;
    if (!rdy || b == 8'h0a) return n;
    case (m.mode)
      "I": begin
        if (b == "L") begin n.mode = "L"; n.nd = 0; n.acc = 0; end
        else if (b == "E") begin n.mode = "E"; n.dmode = 0; n.len = 0; n.ovf = 0; end
        else if (b == "D") begin n.mode = "D"; n.dmode = 1; n.len = 0; n.ovf = 0; n.pend = -1; end
        else if (b != 8'h0d) n.er = 1;
      end
      "L": begin
        if (b == 8'h0d) begin
          if (m.nd == 8) begin n.key = m.acc; n.kv = 1; end
          else n.er = 1;
          n.mode = "I";
        end else if (h >= 0 && m.nd < 8) begin
          n.acc = m.acc * 16 + 32'(h); n.nd++;
        end else begin
          n.er = 1; n.mode = "X";
        end
      end
      "E": begin
        if (b == 8'h0d) begin n.me = 1; n.mode = "I"; end
        else n = emit(n, b);
      end
      "D": begin
        if (b == 8'h0d) begin
          n.me = 1; n.er = (m.pend >= 0); n.pend = -1; n.mode = "I";
        end else if (h < 0) begin
          n.er = 1; n.mode = "X";
        end else if (m.pend < 0) begin
          n.pend = h;
        end else begin
          n = emit(n, 8'(m.pend * 16 + h)); n.pend = -1;
        end
      end
      default: if (b == 8'h0d) n.mode = "I";
    endcase
    return n;
  endfunction

  mdl_t m;
  always @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) m <= mreset();
    else        m <= step(m, rx_data, rx_data_rdy);
  end

  logic [7:0] cap[$];
  int kv_cnt, dv_cnt, me_cnt, er_cnt;

  // Per-cycle comparison against the model, plus pulse capture.
  always @(negedge clk12m) begin
    chk("key", key, m.key);
    chk("key_vld", 32'(key_vld), 32'(m.kv));
    chk("data_vld", 32'(data_vld), 32'(m.dv));
    chk("msg_end", 32'(msg_end), 32'(m.me));
    chk("err", 32'(err), 32'(m.er));
    chk("busy", 32'(busy), 32'(m.mode != "I"));
    chk("msg_len", 32'(msg_len), m.len);
    if (m.dv) chk("data_out", 32'(data_out), 32'(m.dout));
    if (m.dv || m.me) chk("data_mode", 32'(data_mode), 32'(m.dmode));
    if (data_vld) begin cap.push_back(data_out); dv_cnt++; end
    if (key_vld) kv_cnt++;
    if (msg_end) me_cnt++;
    if (err) er_cnt++;
  end

  task automatic clr();
    cap.delete(); kv_cnt = 0; dv_cnt = 0; me_cnt = 0; er_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_data_rdy = 1'b1;
    @(posedge clk12m); #1;
    rx_data_rdy = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    send(8'h0d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk12m); #1; end
  endtask

  logic [7:0] ex[$];
  task automatic chk_cap(input string nm);
    chk({nm, "_count"}, cap.size(), ex.size());
    for (int i = 0; i < ex.size() && i < cap.size(); i++)
      chk({nm, "_byte"}, 32'(cap[i]), 32'(ex[i]));
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_data_rdy = 1'b0;
    clr();
    idle(3);
    chk("rst_key", key, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_len", 32'(msg_len), 32'h0);
    chk("rst_dout", 32'(data_out), 32'h0);
    rst_n = 1'b1;
    idle(2);

    clr(); send_line("L00000000"); idle(2);
    chk("l0_key", key, 32'h0); chk("l0_kv", kv_cnt, 1);
    chk("l0_err", er_cnt, 0); chk("l0_busy", 32'(busy), 0);

    clr(); send_line("Eabcd!"); idle(2);
    ex = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h21}; chk_cap("enc");
    chk("enc_me", me_cnt, 1); chk("enc_len", 32'(msg_len), 5);

    clr(); send_line("L12345678"); send_line("Df0c0276cb0"); idle(2);
    chk("ld_key", key, 32'h12345678);
    ex = '{8'hF0, 8'hC0, 8'h27, 8'h6C, 8'hB0}; chk_cap("dec");
    chk("dec_me", me_cnt, 1); chk("dec_len", 32'(msg_len), 5);

    clr(); send_line("L123"); idle(1);
    chk("short_err", er_cnt, 1); chk("short_key", key, 32'h12345678);

    clr(); send_line("Lx12"); idle(1);
    chk("lx_err", er_cnt, 1); chk("lx_key", key, 32'h12345678);

    clr(); send("Q"); idle(1);
    chk("q_err", er_cnt, 1);

    clr(); send_line("Dabc"); idle(1);
    ex = '{8'hAB}; chk_cap("odd");
    chk("odd_err", er_cnt, 1); chk("odd_me", me_cnt, 1);

    clr(); send("E"); send("x"); send(8'h0a); send("y"); send(8'h0d); idle(1);
    ex = '{8'h78, 8'h79}; chk_cap("lf");

    clr(); send("E");
    for (int i = 0; i < 300; i++) send(8'h41 + 8'(i % 26));
    send(8'h0d); idle(1);
    chk("ovf_dv", dv_cnt, 256); chk("ovf_err", er_cnt, 1);
    chk("ovf_len", 32'(msg_len), 256); chk("ovf_me", me_cnt, 1);

    clr(); send("L"); send("1"); send("2");
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
    chk("rst_mid_key", key, 32'h0);
    send_line("Ez"); idle(2);
    ex = '{8'h7A}; chk_cap("rst_mid");
    chk("rst_mid_kv", kv_cnt, 0); chk("rst_mid_me", me_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
